lifo_stack: RTL and testbench

- Parameterised LIFO return-address/data stack for the MicroEV20 core.
- It is the opposite-ordering counterpart of the 4-entry bit queue: push and pop act on the same end, so the last value in is the first value out.
- Used by the control unit for call/return and for operand save/restore.
- Control-sampled on posedge, with a registered pop output and full/empty/count status plus sticky error flags.

---
 rtl/microev_pkg.sv | 14 +
 rtl/lifo_regfile.sv | 35 +++
 rtl/lifo_stack.sv | 112 +++++++++++
 tb/tb_lifo_stack.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/microev_pkg.sv
// rtl/microev_pkg.sv - shared MicroEV20 stack/queue constants
package microev_pkg;

  // Default geometry of the return-address/data stack.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Op-priority convention shared by the bit queue and the stack:
  // within one edge, pop is evaluated first, then clear, then push.
  // The pop therefore always observes the pre-edge contents, and a push
  // is judged against the occupancy left behind by the pop.
  localparam bit POP_FIRST = 1'b1;

endpackage

// File: rtl/lifo_regfile.sv
// rtl/lifo_regfile.sv - DEPTH x WIDTH register array, 1 sync write, 1 comb read, sync clear
module lifo_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: async reset and sync clear both zero every entry; clear wins over a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: the owner only ever presents an address below DEPTH.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parameterised LIFO stack with registered pop output and sticky errors
module lifo_stack
  import microev_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] P,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    cnt_after_pop;
  logic [WIDTH-1:0] p_q, p_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] top;

  // The top entry sits at count-1; truncating to AW bits is exact because
  // count-1 always lies in [0, DEPTH-1] whenever the read data is used.
  assign raddr = count_q[AW-1:0] - AW'(1);
  assign waddr = cnt_after_pop[AW-1:0];

  lifo_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_regfile (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .we   (we),
    .waddr(waddr),
    .wdata(I),
    .raddr(raddr),
    .rdata(top)
  );

  // Next-state evaluation in pop -> clear -> push order (POP_FIRST).
  always_comb begin
    cnt_after_pop = count_q;
    p_d           = p_q;
    underflow_d   = underflow_q;
    overflow_d    = overflow_q;
    we            = 1'b0;

    if (pop) begin
      if (count_q != '0) begin
        p_d           = top;
        cnt_after_pop = count_q - CW'(1);
      end else begin
        p_d         = '0;
        underflow_d = 1'b1;
      end
    end

    count_d = cnt_after_pop;

    if (clear) begin
      count_d     = '0;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (push) begin
      if (cnt_after_pop < DEPTH_C) begin
        we      = 1'b1;
        count_d = cnt_after_pop + CW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers: count, popped value and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      p_q         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      p_q         <= p_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign P         = p_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - self-checking bench for lifo_stack
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             reset;
  logic             push, pop, clear;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] p;
  logic             empty, full, overflow, underflow;
  logic [CW-1:0]    count;

  int tests;
  int fails;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .I        (din),
    .P        (p),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clear;
    logic [7:0] din;
    logic [7:0] exp_p;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ep, input int ec,
                         input logic eo, input logic eu);
    chk({tag, ".P"}, int'(p), int'(ep));
    chk({tag, ".count"}, int'(count), ec);
    chk({tag, ".empty"}, int'(empty), int'(ec == 0));
    chk({tag, ".full"}, int'(full), int'(ec == DEPTH));
    chk({tag, ".overflow"}, int'(overflow), int'(eo));
    chk({tag, ".underflow"}, int'(underflow), int'(eu));
  endtask

  // Drive one operation set at the falling edge, let a rising edge pass, sample 1ns later.
  task automatic step(input logic pu, input logic po, input logic cl, input logic [7:0] d);
    @(negedge clk);
    push = pu; pop = po; clear = cl; din = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  function automatic vec_t mk(input logic pu, input logic po, input logic cl, input logic [7:0] d,
                              input logic [7:0] ep, input int ec, input logic eo, input logic eu);
    vec_t v;
    v.push = pu; v.pop = po; v.clear = cl; v.din = d;
    v.exp_p = ep; v.exp_count = ec; v.exp_ovf = eo; v.exp_udf = eu;
    return v;
  endfunction

  // Reference model state: plain queue, top of stack is the back.
  logic [7:0] m_q[$];
  logic [7:0] m_p;
  logic       m_ovf, m_udf;

  task automatic model_op(input logic pu, input logic po, input logic cl, input logic [7:0] d);
    if (po) begin
      if (m_q.size() > 0) m_p = m_q.pop_back();
      else begin m_p = 8'h00; m_udf = 1'b1; end
    end
    if (cl) begin
      m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else if (pu) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    push = 0; pop = 0; clear = 0; din = '0;
    reset = 1'b1;
    #12;
    chk_all("reset", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven scenario walk starting from reset.
    vecs.push_back(mk(1,0,0,8'h11, 8'h00,1,0,0));
    vecs.push_back(mk(1,0,0,8'h22, 8'h00,2,0,0));
    vecs.push_back(mk(1,0,0,8'h33, 8'h00,3,0,0));
    vecs.push_back(mk(1,0,0,8'h44, 8'h00,4,0,0));
    vecs.push_back(mk(1,0,0,8'h55, 8'h00,4,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h44,3,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h33,2,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h22,1,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h11,0,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,1,1));
    vecs.push_back(mk(0,0,1,8'h00, 8'h00,0,0,0));
    vecs.push_back(mk(1,1,0,8'h66, 8'h00,1,0,1));
    vecs.push_back(mk(0,1,0,8'h00, 8'h66,0,0,1));
    vecs.push_back(mk(0,0,1,8'h00, 8'h66,0,0,0));
    vecs.push_back(mk(1,0,0,8'hA1, 8'h66,1,0,0));
    vecs.push_back(mk(1,0,0,8'hB2, 8'h66,2,0,0));
    vecs.push_back(mk(1,1,0,8'hC3, 8'hB2,2,0,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'hC3,1,0,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'hA1,0,0,0));
    vecs.push_back(mk(1,0,0,8'h01, 8'hA1,1,0,0));
    vecs.push_back(mk(1,0,0,8'h02, 8'hA1,2,0,0));
    vecs.push_back(mk(1,1,1,8'h77, 8'h02,0,0,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h00,0,0,1));
    vecs.push_back(mk(0,0,1,8'h00, 8'h00,0,0,0));
    vecs.push_back(mk(1,0,0,8'h10, 8'h00,1,0,0));
    vecs.push_back(mk(1,0,0,8'h20, 8'h00,2,0,0));
    vecs.push_back(mk(1,0,0,8'h30, 8'h00,3,0,0));
    vecs.push_back(mk(1,0,0,8'h40, 8'h00,4,0,0));
    vecs.push_back(mk(1,1,0,8'h50, 8'h40,4,0,0));
    vecs.push_back(mk(0,1,0,8'h00, 8'h50,3,0,0));
    vecs.push_back(mk(0,1,1,8'h00, 8'h30,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      push = vecs[i].push; pop = vecs[i].pop; clear = vecs[i].clear; din = vecs[i].din;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_count,
              vecs[i].exp_ovf, vecs[i].exp_udf);
    end
    @(negedge clk);
    push = 0; pop = 0; clear = 0;

    // Async reset between edges with count=3 and both flags set.
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h9A);
    step(1, 0, 0, 8'h9B);
    step(1, 0, 0, 8'h9C);
    step(1, 0, 0, 8'h9D);
    step(1, 0, 0, 8'h9E);
    step(0, 1, 0, 8'h00);
    chk_all("pre_reset", 8'h9D, 3, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 0, 8'h00);
    chk_all("post_reset_pop", 8'h00, 0, 1'b0, 1'b1);
    step(0, 0, 1, 8'h00);

    // Randomised traffic against the queue model.
    m_q.delete(); m_p = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic       pu, po, cl;
      logic [7:0] d;
      pu = 1'($urandom_range(0, 99) < 55);
      po = 1'($urandom_range(0, 99) < 45);
      cl = 1'($urandom_range(0, 99) < 4);
      d  = 8'($urandom);
      @(negedge clk);
      push = pu; pop = po; clear = cl; din = d;
      model_op(pu, po, cl, d);
      @(posedge clk);
      #1;
      chk_all($sformatf("rand%0d", i), m_p, m_q.size(), m_ovf, m_udf);
    end
    @(negedge clk);
    push = 0; pop = 0; clear = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
